// File: rtl/axi4_stream_operand_packer_if.sv
// AXI4-Stream beat channel (tdata/tvalid/tready/tlast) carrying packed operand bytes.
interface axi4_stream_operand_packer_if #(
   parameter int DSZ = 8
);
   logic [DSZ-1:0] tdata;
   logic           tvalid;
   logic           tready;
   logic           tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi4_stream_operand_packer.sv
// Serializes an operand pair {b, a} into one AXI4-Stream packet, LSB first,
// with full backpressure and zero-bubble back-to-back packets.
module axi4_stream_operand_packer #(
   parameter int SZ    = 32,
   parameter int DSZ   = 8,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         _rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [SZ-1:0]                a,
   input  logic [SZ-1:0]                b,
   axi4_stream_operand_packer_if.master m_axis,
   output logic                         busy,
   output logic [CNT_W-1:0]             pkt_count
);

   localparam int NBEATS = 2 * SZ / DSZ;
   localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state_q, state_d;
   logic [2*SZ-1:0]     shreg_q, shreg_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_beat;
   logic                beat_fire;
   logic                capture;

   assign last_beat = (state_q == SEND) && (beat_q == BEAT_W'(NBEATS - 1));
   assign beat_fire = (state_q == SEND) && m_axis.tready;
   // in_ready only looks at state and the last-beat handshake, never at tvalid alone
   assign in_ready  = (state_q == IDLE) || (last_beat && m_axis.tready);
   assign capture   = in_valid && in_ready;

   assign m_axis.tdata  = shreg_q[DSZ-1:0];
   assign m_axis.tvalid = (state_q == SEND);
   assign m_axis.tlast  = last_beat;
   assign busy          = (state_q == SEND);
   assign pkt_count     = cnt_q;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      if (beat_fire) begin
         if (last_beat) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = IDLE;
         end else begin
            shreg_d = shreg_q >> DSZ;
            beat_d  = beat_q + 1'b1;
         end
      end
      // A capture on the tlast handshake overrides the return to IDLE
      if (capture) begin
         shreg_d = {b, a};
         beat_d  = '0;
         state_d = SEND;
      end
   end

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         beat_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         beat_q  <= beat_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_axi4_stream_operand_packer.sv
// Randomized self-checking bench for axi4_stream_operand_packer against a
// byte-order reference model.
module tb_axi4_stream_operand_packer;

   localparam int SZ    = 32;
   localparam int DSZ   = 8;
   localparam int CNT_W = 4;
   localparam int NB    = 2 * SZ / DSZ;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [SZ-1:0]    a;
   logic [SZ-1:0]    b;
   logic             busy;
   logic [CNT_W-1:0] pkt_count;

   axi4_stream_operand_packer_if #(.DSZ(DSZ)) s_if ();

   axi4_stream_operand_packer #(.SZ(SZ), .DSZ(DSZ), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      ._rst      (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .m_axis    (s_if),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int exp_pkts = 0;

   logic [2*SZ-1:0] pairs_q[$];
   logic [2*SZ-1:0] sent[$];
   logic [DSZ-1:0]  got_d[$];
   logic            got_l[$];
   int              stall_viol;
   int              drop_viol;
   int              rdy_viol;
   int              last_cycles;
   bit              timed_out;

   // Beat i of a packet is byte i of the 2*SZ-bit word {b, a}
   function automatic logic [DSZ-1:0] model_beat(input logic [2*SZ-1:0] p, input int i);
      logic [2*SZ-1:0] s;
      s = p >> (DSZ * i);
      return s[DSZ-1:0];
   endfunction

   task automatic offer(input logic [SZ-1:0] oa, input logic [SZ-1:0] ob);
      pairs_q.push_back({ob, oa});
      sent.push_back({ob, oa});
   endtask

   task automatic do_reset();
      in_valid    = 1'b0;
      s_if.tready = 1'b0;
      rst_n       = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_pkts = 0;
   endtask

   // Drives pending pairs and tready; gathers accepted beats and protocol violations.
   // mode 0: tready=1, 1: pattern 1,0,0,1,0,1, 2: random.
   task automatic collect(input int nbeats, input int mode);
      int       accepted;
      int       cyc;
      int       outstanding;
      bit       held;
      logic [DSZ-1:0] held_d;
      logic     held_l;
      logic     exp_rdy;
      int       pat[6];
      pat = '{1, 0, 0, 1, 0, 1};
      accepted = 0; cyc = 0; outstanding = 0; held = 0;
      held_d = '0; held_l = 1'b0;
      got_d.delete(); got_l.delete();
      stall_viol = 0; drop_viol = 0; rdy_viol = 0; timed_out = 0;
      while (accepted < nbeats && cyc < 2000) begin
         in_valid = (pairs_q.size() > 0);
         if (pairs_q.size() > 0) begin
            a = pairs_q[0][SZ-1:0];
            b = pairs_q[0][2*SZ-1:SZ];
         end
         case (mode)
            0:       s_if.tready = 1'b1;
            1:       s_if.tready = pat[cyc % 6] != 0;
            default: s_if.tready = $urandom_range(0, 1) != 0;
         endcase
         @(negedge clk);
         exp_rdy = (outstanding == 0) || (outstanding == 1 && s_if.tready);
         if (in_ready !== exp_rdy) rdy_viol++;
         if (held && (s_if.tdata !== held_d || s_if.tlast !== held_l || s_if.tvalid !== 1'b1))
            stall_viol++;
         if (outstanding > 0 && s_if.tvalid !== 1'b1) drop_viol++;
         held   = s_if.tvalid && !s_if.tready;
         held_d = s_if.tdata;
         held_l = s_if.tlast;
         if (s_if.tvalid && s_if.tready) begin
            got_d.push_back(s_if.tdata);
            got_l.push_back(s_if.tlast);
            accepted++;
            outstanding--;
            if (s_if.tlast) exp_pkts++;
         end
         if (in_valid && in_ready) begin
            void'(pairs_q.pop_front());
            outstanding += NB;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid    = 1'b0;
      s_if.tready = 1'b0;
      last_cycles = cyc;
      if (cyc >= 2000) timed_out = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; in_valid = 1'b0; s_if.tready = 1'b0; a = '0; b = '0;
      #2;
      do_reset();
      #1;
      checks++; if (s_if.tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", s_if.tvalid); else passed++;
      checks++; if (s_if.tlast !== 1'b0) $display("FAIL reset_tlast: got %b expected 0", s_if.tlast); else passed++;
      checks++; if (s_if.tdata !== '0) $display("FAIL reset_tdata: got %h expected 00", s_if.tdata); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
      checks++; if (pkt_count !== '0) $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic [DSZ-1:0] lit[NB];
      lit = '{8'h07, 8'h31, 8'h00, 8'h00, 8'h1D, 8'hA1, 8'h00, 8'h00};
      sent.delete();
      offer(32'd12551, 32'd41245);
      collect(NB, 0);
      checks++; if (timed_out || got_d.size() != NB) $display("FAIL single_count: got %0d beats expected %0d", got_d.size(), NB); else passed++;
      for (int i = 0; i < NB; i++) begin
         checks++;
         if (i >= got_d.size() || got_d[i] !== lit[i] || got_l[i] !== (i == NB - 1))
            $display("FAIL single_beat%0d: got %h/%b expected %h/%b", i,
                     (i < got_d.size()) ? got_d[i] : 8'hxx, (i < got_l.size()) ? got_l[i] : 1'bx, lit[i], i == NB - 1);
         else passed++;
      end
      checks++; if (last_cycles != NB + 1) $display("FAIL single_latency: got %0d cycles expected %0d", last_cycles, NB + 1); else passed++;
      checks++; if (pkt_count !== CNT_W'(exp_pkts)) $display("FAIL single_pkt_count: got %0d expected %0d", pkt_count, exp_pkts % 16); else passed++;
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL single_idle: got rdy=%b busy=%b expected 1/0", in_ready, busy); else passed++;
      checks++; if (rdy_viol != 0) $display("FAIL single_in_ready: got %0d violations expected 0", rdy_viol); else passed++;
   endtask

   task automatic test_backpressure();
      sent.delete();
      offer(32'd12551, 32'd41245);
      collect(NB, 1);
      checks++; if (timed_out || got_d.size() != NB) $display("FAIL bp_count: got %0d beats expected %0d", got_d.size(), NB); else passed++;
      for (int i = 0; i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== model_beat(sent[i / NB], i % NB) || got_l[i] !== (i % NB == NB - 1))
            $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i],
                     model_beat(sent[i / NB], i % NB), i % NB == NB - 1);
         else passed++;
      end
      checks++; if (stall_viol != 0) $display("FAIL bp_hold: got %0d unstable stalls expected 0", stall_viol); else passed++;
      checks++; if (pkt_count !== CNT_W'(exp_pkts)) $display("FAIL bp_pkt_count: got %0d expected %0d", pkt_count, exp_pkts % 16); else passed++;
   endtask

   task automatic test_back_to_back();
      sent.delete();
      offer(32'd12551, 32'd41245);
      offer(32'd1, 32'd2);
      collect(2 * NB, 0);
      checks++; if (timed_out || got_d.size() != 2 * NB) $display("FAIL b2b_count: got %0d beats expected %0d", got_d.size(), 2 * NB); else passed++;
      for (int i = 0; i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== model_beat(sent[i / NB], i % NB) || got_l[i] !== (i % NB == NB - 1))
            $display("FAIL b2b_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i],
                     model_beat(sent[i / NB], i % NB), i % NB == NB - 1);
         else passed++;
      end
      checks++; if (last_cycles != 2 * NB + 1) $display("FAIL b2b_bubbles: got %0d cycles expected %0d", last_cycles, 2 * NB + 1); else passed++;
      checks++; if (drop_viol != 0) $display("FAIL b2b_tvalid_drop: got %0d expected 0", drop_viol); else passed++;
      checks++; if (rdy_viol != 0) $display("FAIL b2b_in_ready: got %0d violations expected 0", rdy_viol); else passed++;
      checks++; if (pkt_count !== CNT_W'(exp_pkts)) $display("FAIL b2b_pkt_count: got %0d expected %0d", pkt_count, exp_pkts % 16); else passed++;
   endtask

   task automatic test_random();
      sent.delete();
      for (int k = 0; k < 3; k++) offer($urandom, $urandom);
      collect(3 * NB, 2);
      checks++; if (timed_out || got_d.size() != 3 * NB) $display("FAIL rnd_count: got %0d beats expected %0d", got_d.size(), 3 * NB); else passed++;
      for (int i = 0; i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== model_beat(sent[i / NB], i % NB) || got_l[i] !== (i % NB == NB - 1))
            $display("FAIL rnd_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i],
                     model_beat(sent[i / NB], i % NB), i % NB == NB - 1);
         else passed++;
      end
      checks++; if (stall_viol != 0 || drop_viol != 0 || rdy_viol != 0)
         $display("FAIL rnd_protocol: got stall=%0d drop=%0d rdy=%0d expected 0/0/0", stall_viol, drop_viol, rdy_viol);
      else passed++;
      checks++; if (pkt_count !== CNT_W'(exp_pkts)) $display("FAIL rnd_pkt_count: got %0d expected %0d", pkt_count, exp_pkts % 16); else passed++;
   endtask

   task automatic test_reset_mid();
      sent.delete();
      offer($urandom, $urandom);
      collect(3, 0);
      for (int i = 0; i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== model_beat(sent[0], i))
            $display("FAIL mid_pre_beat%0d: got %h expected %h", i, got_d[i], model_beat(sent[0], i));
         else passed++;
      end
      #2 rst_n = 1'b0;
      #1;
      exp_pkts = 0;
      checks++; if (s_if.tvalid !== 1'b0 || s_if.tlast !== 1'b0 || busy !== 1'b0)
         $display("FAIL mid_async_outputs: got tvalid=%b tlast=%b busy=%b expected 0/0/0", s_if.tvalid, s_if.tlast, busy);
      else passed++;
      checks++; if (s_if.tdata !== '0 || in_ready !== 1'b1)
         $display("FAIL mid_async_data: got tdata=%h in_ready=%b expected 00/1", s_if.tdata, in_ready);
      else passed++;
      checks++; if (pkt_count !== '0) $display("FAIL mid_pkt_count: got %0d expected 0", pkt_count); else passed++;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      sent.delete();
      offer(32'd1, 32'd2);
      collect(NB, 0);
      checks++; if (timed_out || got_d.size() != NB) $display("FAIL mid_post_count: got %0d beats expected %0d", got_d.size(), NB); else passed++;
      for (int i = 0; i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== model_beat(sent[0], i) || got_l[i] !== (i == NB - 1))
            $display("FAIL mid_post_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], model_beat(sent[0], i), i == NB - 1);
         else passed++;
      end
      checks++; if (pkt_count !== CNT_W'(exp_pkts)) $display("FAIL mid_post_pkt_count: got %0d expected %0d", pkt_count, exp_pkts % 16); else passed++;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         sent.delete();
         offer($urandom, $urandom);
         collect(NB, 0);
         checks++;
         if (timed_out || pkt_count !== CNT_W'(k % 16))
            $display("FAIL wrap_pkt%0d: got %0d expected %0d", k, pkt_count, k % 16);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
